// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache controller.
package icache_pkg;

    localparam int unsigned IDX_W    = 6;
    localparam int unsigned NUM_SETS = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/icache_ctrl_flush_counter.sv
// Set-index walker for the invalidate-all sequence; wraps back to zero.
module flush_counter
    import icache_pkg::*;
#(
    parameter int unsigned W = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == {W{1'b1}});

endmodule

// File: rtl/icache_ctrl.sv
// Two-way instruction-cache controller: zero-latency hits, single-line fills
// and a one-set-per-cycle invalidate-all walk.
module icache_ctrl #(
    parameter int unsigned IDX_W = icache_pkg::IDX_W,
    parameter int unsigned WAYS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_read_i,
    input  logic [IDX_W-1:0] cpu_idx_i,
    output logic             cpu_resp_o,
    input  logic [WAYS-1:0]  way_hit_i,
    input  logic             lru_out_i,
    output logic             hit_way_o,
    output logic             pmem_read_o,
    input  logic             pmem_resp_i,
    output logic [WAYS-1:0]  load_line_o,
    output logic             valid_in_o,
    output logic             load_lru_o,
    output logic             lru_in_o,
    output logic [IDX_W-1:0] arr_windex_o,
    input  logic             flush_i,
    output logic             flush_done_o
);

    import icache_pkg::*;

    state_e           state_q, state_d;
    logic             victim_q, victim_d;
    logic             flush_pend_q, flush_pend_d;
    logic             cnt_en;
    logic [IDX_W-1:0] cnt;
    logic             cnt_wrap;

    flush_counter #(
        .W (IDX_W)
    ) u_flush_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .wrap_o (cnt_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            victim_q     <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        cnt_en       = 1'b0;
        cpu_resp_o   = 1'b0;
        hit_way_o    = 1'b0;
        pmem_read_o  = 1'b0;
        load_line_o  = '0;
        valid_in_o   = 1'b0;
        load_lru_o   = 1'b0;
        lru_in_o     = 1'b0;
        arr_windex_o = '0;
        flush_done_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A pending invalidate outranks any fetch waiting in IDLE.
                if (flush_i || flush_pend_q) begin
                    state_d = S_FLUSH;
                end else if (cpu_read_i) begin
                    if (way_hit_i != '0) begin
                        cpu_resp_o   = 1'b1;
                        hit_way_o    = way_hit_i[1];
                        load_lru_o   = 1'b1;
                        lru_in_o     = ~way_hit_i[1];
                        arr_windex_o = cpu_idx_i;
                    end else begin
                        victim_d = lru_out_i;
                        state_d  = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                pmem_read_o = 1'b1;
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (pmem_resp_i) begin
                    load_line_o[victim_q] = 1'b1;
                    valid_in_o            = 1'b1;
                    load_lru_o            = 1'b1;
                    lru_in_o              = ~victim_q;
                    arr_windex_o          = cpu_idx_i;
                    state_d = (flush_i || flush_pend_q) ? S_FLUSH : S_IDLE;
                end
            end

            S_FLUSH: begin
                cnt_en       = 1'b1;
                load_line_o  = '1;
                load_lru_o   = 1'b1;
                arr_windex_o = cnt;
                if (cnt_wrap) begin
                    flush_done_o = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Both ways matching means the tag arrays are corrupt; way 1 is used anyway.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == S_IDLE && cpu_read_i && way_hit_i == 2'b11))
        else $error("icache_ctrl: both ways hit at idx %0d", cpu_idx_i);

endmodule
